// File: rtl/alu_scheduler.sv
// alu_scheduler: two-port arbiter and operation sequencer in front of the shared ALU.
// Accepts one operation at a time through a valid/ready handshake. It holds the ALU
// operands stable for one execute cycle, or for MULDIV_CYCLES execute cycles on
// mul/div/mod. It then returns the registered result to the winning requester.
// Optional build macro: ALU_SCHED_FIXED_PRIO_EN. When it is defined, requester 0
// always wins a contest. When it is undefined, the two requesters are served round-robin.
module alu_scheduler #(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [5:0]  req_opcode0,
  input  logic [5:0]  req_opcode1,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_b1,
  input  logic [4:0]  req_shamt0,
  input  logic [4:0]  req_shamt1,
  input  logic [1:0]  req_branch,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_result,
  output logic        rsp_sinal_branch,
  output logic [5:0]  alu_opcode,
  output logic [31:0] alu_input1,
  output logic [31:0] alu_input2,
  output logic [4:0]  alu_shamt,
  output logic        alu_branch,
  input  logic [31:0] alu_result,
  input  logic        alu_sinal_branch
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] MULDIV_LOAD = 8'(MULDIV_CYCLES - 1);

  state_t      state;
  logic [5:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [4:0]  shamt_q;
  logic        br_q;
  logic        idx_q;
  logic [7:0]  cnt_q;
`ifndef ALU_SCHED_FIXED_PRIO_EN
  logic        last_grant;
`endif

  logic        any_valid;
  logic        grant_idx;
  logic [5:0]  sel_op;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic [4:0]  sel_shamt;
  logic        sel_br;
  logic        sel_muldiv;

  // Pick the winning requester and mux its operation fields toward the latches
  always_comb begin
    any_valid = |req_valid;
    grant_idx = 1'b0;
`ifdef ALU_SCHED_FIXED_PRIO_EN
    grant_idx = ~req_valid[0];
`else
    if (&req_valid) begin
      grant_idx = ~last_grant;
    end else begin
      grant_idx = req_valid[1];
    end
`endif
    sel_op     = grant_idx ? req_opcode1 : req_opcode0;
    sel_a      = grant_idx ? req_a1      : req_a0;
    sel_b      = grant_idx ? req_b1      : req_b0;
    sel_shamt  = grant_idx ? req_shamt1  : req_shamt0;
    sel_br     = grant_idx ? req_branch[1] : req_branch[0];
    sel_muldiv = (sel_op == 6'b000111) || (sel_op == 6'b001000) || (sel_op == 6'b001001);
  end

  // Ready is raised only in IDLE, and only to the requester that won arbitration
  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE && any_valid) begin
      req_ready = grant_idx ? 2'b10 : 2'b01;
    end
  end

  // The ALU sees the latched operation only while executing and sees zeros otherwise
  always_comb begin
    alu_opcode = '0;
    alu_input1 = '0;
    alu_input2 = '0;
    alu_shamt  = '0;
    alu_branch = 1'b0;
    if (state == EXEC) begin
      alu_opcode = op_q;
      alu_input1 = a_q;
      alu_input2 = b_q;
      alu_shamt  = shamt_q;
      alu_branch = br_q;
    end
  end

  // Main sequencer: accept and latch, count the execute cycles, then pulse the response
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      op_q             <= '0;
      a_q              <= '0;
      b_q              <= '0;
      shamt_q          <= '0;
      br_q             <= 1'b0;
      idx_q            <= 1'b0;
      cnt_q            <= '0;
      rsp_valid        <= 2'b00;
      rsp_result       <= '0;
      rsp_sinal_branch <= 1'b0;
`ifndef ALU_SCHED_FIXED_PRIO_EN
      last_grant       <= 1'b1;
`endif
    end else begin
      rsp_valid <= 2'b00;
      case (state)
        IDLE: begin
          if (any_valid) begin
            op_q    <= sel_op;
            a_q     <= sel_a;
            b_q     <= sel_b;
            shamt_q <= sel_shamt;
            br_q    <= sel_br;
            idx_q   <= grant_idx;
            cnt_q   <= sel_muldiv ? MULDIV_LOAD : 8'd0;
`ifndef ALU_SCHED_FIXED_PRIO_EN
            last_grant <= grant_idx;
`endif
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            rsp_result       <= alu_result;
            rsp_sinal_branch <= alu_sinal_branch;
            rsp_valid        <= idx_q ? 2'b10 : 2'b01;
            state            <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Sequencer and two-port arbiter in front of the shared `alu` instance. Two requesters (instruction datapath on port 0, auxiliary/address unit on port 1) issue ALU operations through a valid/ready handshake. The block picks one requester per operation, holds the ALU operands stable for the required number of cycles, and returns the registered result and branch flag to the winning requester. Multiply, divide and modulo opcodes get a configurable multi-cycle hold; all other opcodes complete in one execute cycle.

## Interface
- `MULDIV_CYCLES`, 4: execute cycles held for opcodes 6'b000111, 6'b001000 and 6'b001001; legal range 1..255.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  2  bit i: requester i has an operation pending.
- `req_ready`  out  2  bit i: requester i's operation is accepted this cycle. At most one bit is set.
- `req_opcode0`, `req_opcode1`  in  6  ALU opcode per requester.
- `req_a0`, `req_a1`, `req_b0`, `req_b1`  in  32  operands per requester.
- `req_shamt0`, `req_shamt1`  in  5  shift amount per requester.
- `req_branch`  in  2  branch qualifier per requester.
- `rsp_valid`  out  2  bit i: one-cycle pulse when requester i's result is on `rsp_result`.
- `rsp_result`  out  32  registered ALU result.
- `rsp_sinal_branch`  out  1  registered ALU branch signal.
- `alu_opcode`  out  6  to `alu.opcode`.
- `alu_input1`, `alu_input2`  out  32  to `alu` operands.
- `alu_shamt`  out  5  to `alu.shamt`.
- `alu_branch`  out  1  to `alu.branch`.
- `alu_result`  in  32  from `alu.result`.
- `alu_sinal_branch`  in  1  from `alu.sinalBranch`.

## Operation
- FSM with three states:
  - IDLE: arbitrate, accept and latch.
  - EXEC: drive the ALU and count cycles.
  - DONE: present the response.
- IDLE:
  - If any `req_valid` bit is set, grant one requester and assert its `req_ready` combinationally.
  - Latch that requester's opcode, a, b, shamt, branch bit and index into the operand registers.
  - Load the cycle counter with `MULDIV_CYCLES-1` for opcodes 000111/001000/001001, else 0.
  - Go to EXEC.
- Arbitration is round-robin:
  - A `last_grant` register resets to 1, so requester 0 wins the first contest.
  - When both requesters are valid, grant the one not equal to `last_grant`.
  - When only one is valid, grant it.
  - Update `last_grant` on every grant.
- EXEC:
  - `alu_*` outputs are driven from the operand registers and stay stable for the whole state.
  - Counter > 0: decrement and stay in EXEC.
  - Counter == 0: capture `alu_result` into `rsp_result` and `alu_sinal_branch` into `rsp_sinal_branch`, then go to DONE.
- DONE:
  - `rsp_valid[idx]` = 1 for exactly one cycle, then go to IDLE.
  - `rsp_result` and `rsp_sinal_branch` hold until the next capture.
- Outside EXEC, `alu_opcode`, `alu_input1`, `alu_input2`, `alu_shamt` and `alu_branch` are all 0.
- Opcodes are passed through unchecked. An undefined opcode still completes in one execute cycle and returns the ALU's default of 0.
- `req_ready` is 0 in EXEC and DONE. Requesters hold their request until they see `req_ready`.

## Timing
- Reset values:
  - State IDLE, `last_grant` = 1.
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_result` = 0, `rsp_sinal_branch` = 0.
  - All `alu_*` outputs = 0.
- Handshake at cycle T (`req_valid` and `req_ready` both high).
  - Single-cycle opcode: EXEC in T+1, `rsp_valid` in T+2.
  - Mul/div/mod: EXEC in T+1..T+MULDIV_CYCLES, `rsp_valid` in T+MULDIV_CYCLES+1.
- Throughput: the earliest next accept is the cycle after DONE, i.e. one operation per 3 cycles minimum.
- `req_ready` depends combinationally on `req_valid` and state only. There is no path from `alu_result` to `req_ready`.
- Reset mid-operation (EXEC or DONE):
  - The operation is aborted and no `rsp_valid` is issued.
  - The FSM returns to IDLE on the next edge and arbitration restarts from `last_grant` = 1.
- A `req_valid` change while the FSM is not in IDLE has no effect.
- `MULDIV_CYCLES` = 1: mul/div/mod time the same as single-cycle opcodes.

## Configuration
- `ALU_SCHED_FIXED_PRIO_EN`:
  - Defined: fixed priority. Requester 0 always wins when both are valid, and `last_grant` is not implemented.
  - Undefined (default): round-robin as described under Operation.
  - Handshake, FSM and timing are identical in both builds.

## Test plan
- Reset, then requester 0 issues opcode 000000 with a = 5, b = 7 -> `req_ready` = 2'b01 in cycle T; `alu_opcode` = 0, `alu_input1` = 5 and `alu_input2` = 7 in T+1; `rsp_valid` = 2'b01 and `rsp_result` = 12 in T+2.
- Both requesters valid simultaneously and continuously, requester 0 ADD, requester 1 SUB 9 - 4 -> grants alternate 0, 1, 0, 1; responses 12 and 5 appear on the matching `rsp_valid` bits.
  - Same scenario with `ALU_SCHED_FIXED_PRIO_EN` defined -> requester 0 is granted every time.
- `MULDIV_CYCLES` = 4, opcode 001000 with a = 100, b = 7 -> EXEC lasts 4 cycles with `alu_*` stable throughout; `rsp_result` = 14 at T+5.
- Opcode 010001 with a = b = 3 and `req_branch` = 1 -> `rsp_sinal_branch` = 1 and `rsp_result` = 0 at T+2. With `req_branch` = 0 -> `rsp_sinal_branch` = 0.
- Assert `reset` during the 2nd EXEC cycle of a divide -> no `rsp_valid` pulse. After reset, with both requesters valid, requester 0 is granted first.
- Undefined opcode 6'b111111 -> completes at T+2 with `rsp_result` = 0. Outside EXEC, all `alu_*` outputs stay 0.
